mbus_lc_tx_sequencer: RTL



---
 rtl/mbus_lc_tx_sequencer.sv | 290 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mbus_lc_tx_sequencer.sv
// -----------------------------------------------------------------------------
// mbus_lc_tx_sequencer
//
// Layer-controller-side initiator for the MBus node TX interface. Local logic
// streams a message as address/data words. Each word is presented to the
// node with a 4-phase TX_REQ/TX_ACK handshake. The message then closes with a
// 4-phase TX_SUCC|TX_FAIL / TX_RESP_ACK completion handshake, and the
// outcome is reported on DONE/STATUS.
//
// Optional build macro: MBUS_LC_TX_RETRY_EN
//   When defined, a single-word message that ends with bus-fail status is
//   re-sent from the held word registers after the completion handshake. This
//   repeats up to MAX_RETRY times. DONE is held back until the message
//   succeeds or the retries run out. When undefined, no retry logic exists.
//
// Ports
//   CLKIN        in   layer-controller clock
//   RESET        in   synchronous, active-high reset
//   MSG_VALID    in   word available from the local master
//   MSG_READY    out  word accepted when MSG_VALID & MSG_READY
//   MSG_ADDR     in   destination address, sampled on the first word only
//   MSG_DATA     in   payload word
//   MSG_LAST     in   final word of the message
//   MSG_PRIORITY in   priority request, sampled on the first word only
//   TX_ADDR      out  address to node
//   TX_DATA      out  data to node
//   TX_REQ       out  word request
//   TX_PEND      out  more words follow the current one
//   TX_PRIORITY  out  priority request to node
//   TX_ACK       in   word acknowledge from node (asynchronous)
//   TX_SUCC      in   message success from node (asynchronous)
//   TX_FAIL      in   message failure from node (asynchronous)
//   TX_RESP_ACK  out  completion acknowledge to node
//   DONE         out  one-cycle pulse at message end
//   STATUS       out  00 success, 01 bus fail, 10 ack timeout (valid with DONE)
//   BUSY         out  high whenever the sequencer is not idle
//   DBG_STATE    out  current FSM state encoding (debug observation)
//
// Local handshake: a word transfers on a rising CLKIN edge where MSG_VALID and
// MSG_READY are both high. MSG_READY is registered and does not depend on
// MSG_VALID. The master must hold MSG_ADDR/DATA/LAST/PRIORITY stable while
// MSG_VALID is high and not yet accepted.
// -----------------------------------------------------------------------------
module mbus_lc_tx_sequencer #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int ACK_TIMEOUT = 1024,
  parameter int MAX_RETRY   = 3
) (
  input  logic                  CLKIN,
  input  logic                  RESET,
  input  logic                  MSG_VALID,
  output logic                  MSG_READY,
  input  logic [ADDR_WIDTH-1:0] MSG_ADDR,
  input  logic [DATA_WIDTH-1:0] MSG_DATA,
  input  logic                  MSG_LAST,
  input  logic                  MSG_PRIORITY,
  output logic [ADDR_WIDTH-1:0] TX_ADDR,
  output logic [DATA_WIDTH-1:0] TX_DATA,
  output logic                  TX_REQ,
  output logic                  TX_PEND,
  output logic                  TX_PRIORITY,
  input  logic                  TX_ACK,
  input  logic                  TX_SUCC,
  input  logic                  TX_FAIL,
  output logic                  TX_RESP_ACK,
  output logic                  DONE,
  output logic [1:0]            STATUS,
  output logic                  BUSY,
  output logic [2:0]            DBG_STATE
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REQ      = 3'd1,
    S_DROP     = 3'd2,
    S_NEXT     = 3'd3,
    S_WAIT_RES = 3'd4,
    S_FLUSH    = 3'd5,
    S_RESP     = 3'd6,
    S_DONE     = 3'd7
  } state_t;

  localparam logic [1:0]  ST_SUCC    = 2'b00;
  localparam logic [1:0]  ST_FAIL    = 2'b01;
  localparam logic [1:0]  ST_TIMEOUT = 2'b10;
  localparam logic [15:0] TO_LIM     = 16'(ACK_TIMEOUT);

  state_t      state;
  logic        ack_m, ack_s;
  logic        succ_m, succ_s;
  logic        fail_m, fail_s;
  logic [15:0] to_cnt;
  logic [15:0] to_next;
  logic        discard;   // FLUSH still has to swallow words up to MSG_LAST
  logic        accept;

`ifdef MBUS_LC_TX_RETRY_EN
  localparam logic [7:0] RETRY_LIM = 8'(MAX_RETRY);
  logic       single;     // message consisted of exactly one word
  logic [7:0] retry_cnt;
`else
  logic unused_retry_cfg;
  assign unused_retry_cfg = (MAX_RETRY != 0);
`endif

  assign accept    = MSG_VALID & MSG_READY;
  assign DBG_STATE = state;

  // Saturating increment: the timeout counter never wraps back to zero.
  assign to_next = (to_cnt == 16'hFFFF) ? to_cnt : to_cnt + 16'd1;

  // Two-flop synchronizers for the node-side asynchronous inputs.
  always_ff @(posedge CLKIN) begin
    if (RESET) begin
      ack_m  <= 1'b0;
      ack_s  <= 1'b0;
      succ_m <= 1'b0;
      succ_s <= 1'b0;
      fail_m <= 1'b0;
      fail_s <= 1'b0;
    end else begin
      ack_m  <= TX_ACK;
      ack_s  <= ack_m;
      succ_m <= TX_SUCC;
      succ_s <= succ_m;
      fail_m <= TX_FAIL;
      fail_s <= fail_m;
    end
  end

  always_ff @(posedge CLKIN) begin
    if (RESET) begin
      state       <= S_IDLE;
      MSG_READY   <= 1'b0;
      TX_ADDR     <= '0;
      TX_DATA     <= '0;
      TX_REQ      <= 1'b0;
      TX_PEND     <= 1'b0;
      TX_PRIORITY <= 1'b0;
      TX_RESP_ACK <= 1'b0;
      DONE        <= 1'b0;
      STATUS      <= 2'b00;
      BUSY        <= 1'b0;
      to_cnt      <= '0;
      discard     <= 1'b0;
`ifdef MBUS_LC_TX_RETRY_EN
      single      <= 1'b0;
      retry_cnt   <= '0;
`endif
    end else begin
      DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            TX_ADDR     <= MSG_ADDR;
            TX_DATA     <= MSG_DATA;
            TX_PEND     <= ~MSG_LAST;
            TX_PRIORITY <= MSG_PRIORITY;
            TX_REQ      <= 1'b1;
            to_cnt      <= '0;
            MSG_READY   <= 1'b0;
            BUSY        <= 1'b1;
            state       <= S_REQ;
`ifdef MBUS_LC_TX_RETRY_EN
            single      <= MSG_LAST;
            retry_cnt   <= '0;
`endif
          end else begin
            MSG_READY <= 1'b1;
            BUSY      <= 1'b0;
          end
        end

        S_REQ: begin
          if (ack_s) begin
            TX_REQ <= 1'b0;
            state  <= S_DROP;
          end else if (fail_s) begin
            // Bus aborted: the rest of the message still has to be drained
            // unless the word on the bus was already the last one.
            TX_REQ    <= 1'b0;
            STATUS    <= ST_FAIL;
            discard   <= TX_PEND;
            MSG_READY <= TX_PEND;
            state     <= S_FLUSH;
          end else if (to_next >= TO_LIM) begin
            TX_REQ    <= 1'b0;
            STATUS    <= ST_TIMEOUT;
            to_cnt    <= to_next;
            discard   <= TX_PEND;
            MSG_READY <= TX_PEND;
            state     <= S_FLUSH;
          end else begin
            to_cnt <= to_next;
          end
        end

        S_DROP: begin
          if (!ack_s) begin
            if (!TX_PEND) begin
              state <= S_WAIT_RES;
            end else begin
              MSG_READY <= 1'b1;
              state     <= S_NEXT;
            end
          end
        end

        S_NEXT: begin
          if (fail_s) begin
            // A word accepted in this same cycle is consumed, so the drain
            // is already over if that word was the last one.
            STATUS    <= ST_FAIL;
            discard   <= ~(accept & MSG_LAST);
            MSG_READY <= ~(accept & MSG_LAST);
            state     <= S_FLUSH;
          end else if (accept) begin
            TX_DATA   <= MSG_DATA;
            TX_PEND   <= ~MSG_LAST;
            TX_REQ    <= 1'b1;
            to_cnt    <= '0;
            MSG_READY <= 1'b0;
            state     <= S_REQ;
          end
        end

        S_WAIT_RES: begin
          // Fail takes precedence when both results are visible together.
          if (fail_s) begin
            STATUS      <= ST_FAIL;
            TX_RESP_ACK <= 1'b1;
            state       <= S_RESP;
          end else if (succ_s) begin
            STATUS      <= ST_SUCC;
            TX_RESP_ACK <= 1'b1;
            state       <= S_RESP;
          end
        end

        S_FLUSH: begin
          if (discard) begin
            if (accept && MSG_LAST) begin
              discard   <= 1'b0;
              MSG_READY <= 1'b0;
            end
          end else if (succ_s || fail_s) begin
            TX_RESP_ACK <= 1'b1;
            state       <= S_RESP;
          end else begin
            DONE  <= 1'b1;
            state <= S_DONE;
          end
        end

        S_RESP: begin
          if (!succ_s && !fail_s) begin
            TX_RESP_ACK <= 1'b0;
`ifdef MBUS_LC_TX_RETRY_EN
            if (single && (STATUS == ST_FAIL) && (retry_cnt < RETRY_LIM)) begin
              // Re-send the held word; address/data/priority are unchanged.
              retry_cnt <= retry_cnt + 8'd1;
              TX_REQ    <= 1'b1;
              to_cnt    <= '0;
              state     <= S_REQ;
            end else begin
              DONE  <= 1'b1;
              state <= S_DONE;
            end
`else
            DONE  <= 1'b1;
            state <= S_DONE;
`endif
          end
        end

        S_DONE: begin
          MSG_READY <= 1'b1;
          BUSY      <= 1'b0;
          state     <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
